// File: rtl/mem_stage_async_if.sv
// mem_stage_async_if: EX->MS->WB handshake, data-bus response and ID forwarding bundle
interface mem_stage_async_if;
  logic        flush;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_alu_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_res_from_mem;
  logic [2:0]  es_load_op;
  logic [31:0] es_rt_value;
  logic        es_req_sent;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_disc_full;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic [31:0] ms_final_result;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_pending;
  modport master (
    output flush, es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we, es_res_from_mem,
           es_load_op, es_rt_value, es_req_sent, data_sram_data_ok, data_sram_rdata, ws_allowin,
    input  ms_allowin, ms_disc_full, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
           ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_pending
  );
  modport slave (
    input  flush, es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we, es_res_from_mem,
           es_load_op, es_rt_value, es_req_sent, data_sram_data_ok, data_sram_rdata, ws_allowin,
    output ms_allowin, ms_disc_full, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
           ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_pending
  );
endinterface

// File: rtl/mem_stage_async.sv
// mem_stage_async: MIPS memory stage with variable-latency load data, load alignment and flush-orphan discard
module mem_stage_async #(
  parameter int DISC_W    = 2,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  mem_stage_async_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_HAVE = 2'd2;
  logic              r_valid;
  logic [1:0]        r_state;
  logic [DISC_W-1:0] r_disc;
  logic [31:0]       r_rdata_buf, r_pc, r_alu, r_rt;
  logic [4:0]        r_dest;
  logic              r_gr_we, r_from_mem;
  logic [2:0]        r_op;
  logic              w_live_ok, w_ready_go, w_allowin, w_latch, w_inc_ms, w_inc_es, w_dec;
  logic [1:0]        w_a;
  logic [7:0]        w_b;
  logic [15:0]       w_h;
  logic [31:0]       w_d, w_lwl, w_lwr, w_load, w_final;
  // a response only belongs to the current load once every orphan ahead of it has drained
  assign w_live_ok  = bus.data_sram_data_ok && r_disc == '0;
  assign w_ready_go = r_state == S_IDLE || r_state == S_HAVE || (r_state == S_WAIT && w_live_ok && BYPASS_EN);
  assign w_allowin  = !r_valid || (w_ready_go && bus.ws_allowin);
  assign w_latch    = bus.es_to_ms_valid && w_allowin && !bus.flush;
  assign w_inc_ms   = bus.flush && r_state == S_WAIT && !w_live_ok;
  assign w_inc_es   = bus.flush && bus.es_to_ms_valid && bus.es_req_sent;
  assign w_dec      = bus.data_sram_data_ok && r_disc != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_state     <= S_IDLE;
      r_disc      <= '0;
      r_rdata_buf <= '0;
    end else begin
      r_valid <= !bus.flush && (w_allowin ? bus.es_to_ms_valid : r_valid);
      r_state <= bus.flush ? S_IDLE :
                 w_allowin ? ((w_latch && bus.es_req_sent) ? S_WAIT : S_IDLE) :
                 (r_state == S_WAIT && w_live_ok) ? S_HAVE : r_state;
      r_disc  <= r_disc + DISC_W'(w_inc_ms) + DISC_W'(w_inc_es) - DISC_W'(w_dec);
      if (r_state == S_WAIT && w_live_ok) r_rdata_buf <= bus.data_sram_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_pc       <= bus.es_pc;
      r_alu      <= bus.es_alu_result;
      r_rt       <= bus.es_rt_value;
      r_dest     <= bus.es_dest;
      r_gr_we    <= bus.es_gr_we;
      r_from_mem <= bus.es_res_from_mem;
      r_op       <= bus.es_load_op;
    end
  end
  assign w_a   = r_alu[1:0];
  assign w_d   = r_state == S_HAVE ? r_rdata_buf : bus.data_sram_rdata;
  assign w_b   = w_d[{w_a, 3'b000} +: 8];
  assign w_h   = w_a[1] ? w_d[31:16] : w_d[15:0];
  assign w_lwl = w_a == 2'd0 ? {w_d[7:0], r_rt[23:0]} :
                 w_a == 2'd1 ? {w_d[15:0], r_rt[15:0]} :
                 w_a == 2'd2 ? {w_d[23:0], r_rt[7:0]} : w_d;
  assign w_lwr = w_a == 2'd0 ? w_d :
                 w_a == 2'd1 ? {r_rt[31:24], w_d[31:8]} :
                 w_a == 2'd2 ? {r_rt[31:16], w_d[31:16]} : {r_rt[31:8], w_d[31:24]};
  assign w_load = r_op == 3'd1 ? {{24{w_b[7]}}, w_b} :
                  r_op == 3'd2 ? {{16{w_h[15]}}, w_h} :
                  r_op == 3'd3 ? {24'd0, w_b} :
                  r_op == 3'd4 ? {16'd0, w_h} :
                  r_op == 3'd5 ? w_lwl :
                  r_op == 3'd6 ? w_lwr : w_d;
  assign w_final = r_from_mem ? w_load : r_alu;
  assign bus.ms_allowin      = w_allowin;
  assign bus.ms_disc_full    = r_disc >= DISC_W'((1 << DISC_W) - 2);
  assign bus.ms_to_ws_valid  = r_valid && w_ready_go && !bus.flush;
  assign bus.ms_pc           = r_pc;
  assign bus.ms_dest         = r_dest;
  assign bus.ms_gr_we        = r_gr_we;
  assign bus.ms_final_result = w_final;
  assign bus.ms_fwd_valid    = r_valid && r_gr_we && !bus.flush;
  assign bus.ms_fwd_dest     = r_dest;
  assign bus.ms_fwd_data     = w_final;
  assign bus.ms_fwd_pending  = bus.ms_fwd_valid && r_from_mem && !w_ready_go;
endmodule

// File: tb/tb_mem_stage_async.sv
// tb_mem_stage_async: directed scenarios plus randomized traffic against a queue-based reference model
module tb_mem_stage_async;
  typedef struct {
    logic [31:0] pc, alu, rt;
    logic [4:0]  dest;
    logic        we, mem, req;
    logic [2:0]  op;
  } ins_t;
  typedef struct {
    logic [31:0] data;
    bit          live;
  } rsp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  mem_stage_async_if bus();
  mem_stage_async #(.DISC_W(2), .BYPASS_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nx();
    @(negedge clk);
    bus.flush = 1'b0;
    bus.es_to_ms_valid = 1'b0;
    bus.es_req_sent = 1'b0;
    bus.data_sram_data_ok = 1'b0;
  endtask
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest, input logic we,
                       input logic mem, input logic [2:0] op, input logic [31:0] rt, input logic req);
    bus.es_to_ms_valid = 1'b1;
    bus.es_pc = pc;
    bus.es_alu_result = alu;
    bus.es_dest = dest;
    bus.es_gr_we = we;
    bus.es_res_from_mem = mem;
    bus.es_load_op = op;
    bus.es_rt_value = rt;
    bus.es_req_sent = req;
  endtask
  task automatic resp(input logic [31:0] d);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = d;
  endtask
  function automatic ins_t rand_ins(input bit allow_ld);
    ins_t t;
    t.pc = $urandom;
    t.alu = $urandom;
    t.rt = $urandom;
    t.dest = 5'($urandom);
    t.we = $urandom_range(0, 3) != 0;
    t.mem = allow_ld && $urandom_range(0, 9) < 6;
    t.op = 3'($urandom_range(0, 6));
    if (t.mem && (t.op == 3'd2 || t.op == 3'd4)) t.alu[0] = 1'b0;
    t.req = t.mem;
    return t;
  endfunction
  function automatic logic [31:0] ref_res(input ins_t t, input logic [31:0] d);
    int a;
    logic [31:0] b, h;
    a = int'(t.alu[1:0]);
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    if (!t.mem) return t.alu;
    case (t.op)
      3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd3: return b;
      3'd4: return h;
      3'd5: return (d << (8 * (3 - a))) | (t.rt & (32'h00FF_FFFF >> (8 * a)));
      3'd6: return (d >> (8 * a)) | (t.rt & ~(32'hFFFF_FFFF >> (8 * a)));
      default: return d;
    endcase
  endfunction
  initial begin
    rsp_t bq[$];
    rsp_t head, nr;
    ins_t ms, pres;
    bit occ, got, has_pres, rsp_ok, live, ready, exp_allowin;
    int dead;
    logic [31:0] gdata;
    bus.ws_allowin = 1'b1;
    bus.es_pc = '0;
    bus.es_alu_result = '0;
    bus.es_dest = '0;
    bus.es_gr_we = 1'b0;
    bus.es_res_from_mem = 1'b0;
    bus.es_load_op = '0;
    bus.es_rt_value = '0;
    bus.data_sram_rdata = '0;
    nx();
    nx(); #1;
    chk("rst_tows", bus.ms_to_ws_valid, 0);
    chk("rst_fwd", bus.ms_fwd_valid, 0);
    chk("rst_pend", bus.ms_fwd_pending, 0);
    chk("rst_full", bus.ms_disc_full, 0);
    chk("rst_allowin", bus.ms_allowin, 1);
    reset = 1'b0;
    nx(); issue(32'h100, 32'h1003, 5'd7, 1, 1, 3'd1, 0, 1); #1;
    chk("lb_allowin", bus.ms_allowin, 1);
    nx(); #1;
    chk("lb_wait_tows", bus.ms_to_ws_valid, 0);
    chk("lb_wait_pend", bus.ms_fwd_pending, 1);
    nx(); #1;
    chk("lb_wait2_tows", bus.ms_to_ws_valid, 0);
    nx(); resp(32'h80FF_0000); #1;
    chk("lb_tows", bus.ms_to_ws_valid, 1);
    chk("lb_res", bus.ms_final_result, 32'hFFFF_FF80);
    chk("lb_pc", bus.ms_pc, 32'h100);
    chk("lb_bypass_allowin", bus.ms_allowin, 1);
    nx(); #1;
    chk("lb_gone", bus.ms_to_ws_valid, 0);
    issue(32'h104, 32'h2002, 5'd8, 1, 1, 3'd6, 32'h1122_3344, 1);
    nx(); resp(32'hAABB_CCDD); #1;
    chk("lwr_res", bus.ms_final_result, 32'h1122_AABB);
    nx(); issue(32'h108, 32'h2001, 5'd8, 1, 1, 3'd5, 32'h1122_3344, 1);
    nx(); resp(32'hAABB_CCDD); #1;
    chk("lwl_res", bus.ms_final_result, 32'hCCDD_3344);
    nx(); issue(32'h10C, 32'h3000, 5'd9, 1, 1, 3'd0, 0, 1);
    nx(); bus.ws_allowin = 1'b0; resp(32'h1234_5678); #1;
    chk("have_tows", bus.ms_to_ws_valid, 1);
    chk("have_allowin0", bus.ms_allowin, 0);
    for (int i = 0; i < 2; i++) begin
      nx(); bus.data_sram_rdata = '0; #1;
      chk("have_hold", bus.ms_final_result, 32'h1234_5678);
      chk("have_allowin", bus.ms_allowin, 0);
    end
    nx(); bus.ws_allowin = 1'b1; #1;
    chk("have_deliver", bus.ms_final_result, 32'h1234_5678);
    chk("have_deliver_v", bus.ms_to_ws_valid, 1);
    nx(); #1;
    chk("have_once", bus.ms_to_ws_valid, 0);
    issue(32'h110, 32'h4000, 5'd10, 1, 1, 3'd0, 0, 1);
    nx(); bus.flush = 1'b1; #1;
    chk("fl_fwd", bus.ms_fwd_valid, 0);
    chk("fl_tows", bus.ms_to_ws_valid, 0);
    nx(); issue(32'h114, 32'h4004, 5'd11, 1, 1, 3'd0, 0, 1); #1;
    chk("fl_full", bus.ms_disc_full, 0);
    chk("fl_allowin", bus.ms_allowin, 1);
    nx(); resp(32'h0000_DEAD); #1;
    chk("fl_drop", bus.ms_to_ws_valid, 0);
    chk("fl_pend", bus.ms_fwd_pending, 1);
    nx(); resp(32'h0000_BEEF); #1;
    chk("fl_live", bus.ms_to_ws_valid, 1);
    chk("fl_res", bus.ms_final_result, 32'h0000_BEEF);
    chk("fl_pc", bus.ms_pc, 32'h114);
    nx(); issue(32'h118, 32'h5000, 5'd12, 1, 1, 3'd0, 0, 1);
    nx(); bus.flush = 1'b1; issue(32'h11C, 32'h5004, 5'd13, 1, 1, 3'd0, 0, 1);
    nx(); #1;
    chk("df_full", bus.ms_disc_full, 1);
    chk("df_empty", bus.ms_to_ws_valid, 0);
    nx(); resp(32'h1); #1;
    chk("df_drop1", bus.ms_to_ws_valid, 0);
    nx(); #1;
    chk("df_full1", bus.ms_disc_full, 0);
    nx(); resp(32'h2); #1;
    nx(); #1;
    chk("df_clear", bus.ms_disc_full, 0);
    issue(32'h120, 32'h5008, 5'd14, 1, 1, 3'd0, 0, 1);
    nx(); resp(32'h0000_0077); #1;
    chk("df_live", bus.ms_to_ws_valid, 1);
    chk("df_res", bus.ms_final_result, 32'h77);
    nx(); issue(32'h124, 32'hCAFE_0005, 5'd5, 1, 0, 3'd0, 0, 0);
    nx(); issue(32'h128, 32'h6000, 5'd5, 1, 1, 3'd0, 0, 1); #1;
    chk("fw_alu_v", bus.ms_fwd_valid, 1);
    chk("fw_alu_dest", bus.ms_fwd_dest, 5);
    chk("fw_alu_data", bus.ms_fwd_data, 32'hCAFE_0005);
    chk("fw_alu_pend", bus.ms_fwd_pending, 0);
    for (int i = 0; i < 2; i++) begin
      nx(); #1;
      chk("fw_ld_pend", bus.ms_fwd_pending, 1);
      chk("fw_ld_dest", bus.ms_fwd_dest, 5);
    end
    nx(); resp(32'h600D_F00D); #1;
    chk("fw_ld_done", bus.ms_fwd_pending, 0);
    chk("fw_ld_data", bus.ms_fwd_data, 32'h600D_F00D);
    nx(); issue(32'h12C, 32'h7000, 5'd3, 1, 1, 3'd0, 0, 1);
    nx(); reset = 1'b1;
    nx(); #1;
    chk("rstw_tows", bus.ms_to_ws_valid, 0);
    chk("rstw_allowin", bus.ms_allowin, 1);
    chk("rstw_full", bus.ms_disc_full, 0);
    reset = 1'b0;
    occ = 0; got = 0; has_pres = 0; gdata = '0;
    for (int c = 0; c < 3000; c++) begin
      nx();
      dead = 0;
      foreach (bq[i]) if (!bq[i].live) dead++;
      if (!has_pres && $urandom_range(0, 3) != 0) begin
        pres = rand_ins(dead < 2);
        has_pres = 1;
      end
      bus.ws_allowin = $urandom_range(0, 9) < 7;
      bus.flush = $urandom_range(0, 29) == 0;
      rsp_ok = bq.size() > 0 && $urandom_range(0, 9) < 4;
      if (rsp_ok) begin
        head = bq[0];
        resp(head.data);
      end
      if (has_pres) issue(pres.pc, pres.alu, pres.dest, pres.we, pres.mem, pres.op, pres.rt, pres.req);
      #1;
      live = rsp_ok && head.live;
      ready = occ && (!ms.mem || got || live);
      exp_allowin = !occ || (ready && bus.ws_allowin);
      chk("r_allowin", bus.ms_allowin, exp_allowin);
      chk("r_tows", bus.ms_to_ws_valid, ready && !bus.flush);
      chk("r_full", bus.ms_disc_full, dead >= 2);
      chk("r_pend", bus.ms_fwd_pending, occ && ms.we && ms.mem && !ready && !bus.flush);
      if (ready && !bus.flush) begin
        chk("r_res", bus.ms_final_result, ref_res(ms, got ? gdata : head.data));
        chk("r_pc", bus.ms_pc, ms.pc);
        chk("r_dest", bus.ms_dest, ms.dest);
      end
      if (rsp_ok) void'(bq.pop_front());
      if (bus.flush) begin
        foreach (bq[i]) bq[i].live = 0;
        if (has_pres && pres.req) begin
          nr.data = $urandom;
          nr.live = 0;
          bq.push_back(nr);
        end
        occ = 0;
        has_pres = 0;
      end else begin
        if (occ && !exp_allowin && live) begin
          got = 1;
          gdata = head.data;
        end
        if (exp_allowin) begin
          occ = has_pres;
          if (has_pres) begin
            ms = pres;
            got = 0;
            if (pres.req) begin
              nr.data = $urandom;
              nr.live = 1;
              bq.push_back(nr);
            end
          end
          has_pres = 0;
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
